// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: FSM encoding,
// frame-length constants used by the abort timer, and the layout of
// a result FIFO entry.
package uart_rx_pkg;

    // Frame sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } rx_state_e;

    // Start + 8 data + stop bits, an optional parity bit, and one guard
    // bit of slack so a slow frame is not cut off right at its stop bit.
    localparam int FRAME_BASE_BITS  = 10;
    localparam int FRAME_PAR_BITS   = 1;
    localparam int FRAME_GUARD_BITS = 1;

    // Error flags sit directly above the data field in each FIFO entry
    localparam int ENT_PAR_OFS   = 0;
    localparam int ENT_STP_OFS   = 1;
    localparam int ENT_FLAG_BITS = 2;

    function automatic int entry_width(input int data_w);
        return data_w + ENT_FLAG_BITS;
    endfunction

endpackage

// File: rtl/uart_rx_res_fifo.sv
// Synchronous first-word-fall-through FIFO holding received bytes and
// their error flags. A write on a full FIFO is accepted only when a
// read frees a slot in the same cycle.
module uart_rx_res_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_ok;
    logic              wr_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: owns the receiver configuration (changed only
// between frames), tracks frame activity with an abort timer, buffers
// received bytes in a result FIFO and keeps saturating error statistics.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int PRESCALE_W   = 6,
    parameter int FIFO_DEPTH   = 4,
    parameter int TO_W         = 10,
    parameter int RST_PRESCALE = 8,
    parameter int CNT_W        = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          rx_in,
    input  logic [PRESCALE_W-1:0]         cfg_prescale,
    input  logic                          cfg_par_en,
    input  logic                          cfg_par_typ,
    input  logic                          cfg_wr,
    output logic                          cfg_pending,
    output logic [PRESCALE_W-1:0]         rx_prescale,
    output logic                          rx_par_en,
    output logic                          rx_par_typ,
    input  logic                          rx_data_valid,
    input  logic                          rx_par_err,
    input  logic                          rx_stp_err,
    input  logic [DATA_W-1:0]             rx_p_data,
    output logic                          frame_active,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_par_err,
    output logic                          m_stp_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [CNT_W-1:0]              err_cnt,
    output logic [CNT_W-1:0]              to_cnt,
    input  logic                          cnt_clr
);

    localparam int ENT_W = entry_width(DATA_W);

    rx_state_e             state_q;
    rx_state_e             state_d;
    logic [TO_W-1:0]       timer_q;
    logic [TO_W-1:0]       prescale_ext;
    logic [TO_W-1:0]       frame_bits;
    logic [TO_W-1:0]       limit;
    logic [PRESCALE_W-1:0] shd_prescale;
    logic                  shd_par_en;
    logic                  shd_par_typ;
    logic                  cfg_wr_ok;
    logic                  end_strobe;
    logic                  push;
    logic                  timeout_hit;
    logic                  apply_cfg;
    logic                  pop;
    logic                  drop;
    logic                  err_inc;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENT_W-1:0]      entry_in;
    logic [ENT_W-1:0]      entry_out;

    assign end_strobe = rx_data_valid || rx_par_err || rx_stp_err;
    assign cfg_wr_ok  = cfg_wr && (cfg_prescale != '0);

    // Abort limit is one frame length in sample ticks, minus one since the timer starts at zero
    assign prescale_ext = TO_W'(rx_prescale);
    assign frame_bits   = rx_par_en ? TO_W'(FRAME_BASE_BITS + FRAME_PAR_BITS + FRAME_GUARD_BITS)
                                    : TO_W'(FRAME_BASE_BITS + FRAME_GUARD_BITS);
    assign limit        = (prescale_ext * frame_bits) - TO_W'(1);

    // Frame sequencing state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a low line starts a frame, DONE holds until the line idles high
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_in) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (end_strobe || (timer_q == limit)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rx_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-state actions: config apply only on a quiet IDLE cycle, push or timeout while ACTIVE
    always_comb begin
        frame_active = 1'b0;
        push         = 1'b0;
        timeout_hit  = 1'b0;
        apply_cfg    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                apply_cfg = rx_in && cfg_pending;
            end
            ST_ACTIVE: begin
                frame_active = 1'b1;
                push         = end_strobe;
                timeout_hit  = !end_strobe && (timer_q == limit);
            end
            default: ;
        endcase
    end

    // Abort timer runs only while a frame is in progress and restarts from zero each frame
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            timer_q <= '0;
        end else if (state_q == ST_ACTIVE) begin
            timer_q <= timer_q + TO_W'(1);
        end else begin
            timer_q <= '0;
        end
    end

    // Shadow capture and between-frame apply; a write in the apply cycle stays pending
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shd_prescale <= PRESCALE_W'(RST_PRESCALE);
            shd_par_en   <= 1'b0;
            shd_par_typ  <= 1'b0;
            rx_prescale  <= PRESCALE_W'(RST_PRESCALE);
            rx_par_en    <= 1'b0;
            rx_par_typ   <= 1'b0;
            cfg_pending  <= 1'b0;
        end else begin
            if (cfg_wr_ok) begin
                shd_prescale <= cfg_prescale;
                shd_par_en   <= cfg_par_en;
                shd_par_typ  <= cfg_par_typ;
            end
            if (apply_cfg) begin
                rx_prescale <= shd_prescale;
                rx_par_en   <= shd_par_en;
                rx_par_typ  <= shd_par_typ;
            end
            if (cfg_wr_ok) begin
                cfg_pending <= 1'b1;
            end else if (apply_cfg) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    // Pack the entry with the error flags above the data byte
    always_comb begin
        entry_in                         = '0;
        entry_in[DATA_W-1:0]             = rx_p_data;
        entry_in[DATA_W + ENT_PAR_OFS]   = rx_par_err;
        entry_in[DATA_W + ENT_STP_OFS]   = rx_stp_err;
    end

    assign pop     = m_valid && m_ready;
    assign drop    = push && fifo_full && !pop;
    assign err_inc = push && (rx_par_err || rx_stp_err);

    uart_rx_res_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk     (CLK),
        .rst_n   (RST),
        .wr_en   (push),
        .wr_data (entry_in),
        .rd_en   (m_ready),
        .rd_data (entry_out),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_valid   = !fifo_empty;
    assign m_data    = entry_out[DATA_W-1:0];
    assign m_par_err = entry_out[DATA_W + ENT_PAR_OFS];
    assign m_stp_err = entry_out[DATA_W + ENT_STP_OFS];

    // Sticky overflow: a lost frame wins over a clear in the same cycle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Saturating statistics; clear beats increment
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_cnt <= '0;
            to_cnt  <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if (err_inc && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (timeout_hit && (to_cnt != '1)) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed scenarios plus randomized frames,
// config writes and timeouts. Expected FIFO entries go into a queue and a
// monitor compares them whenever the consumer accepts a head entry.
module tb_uart_rx_ctrl;

    localparam int DATA_W       = 8;
    localparam int PRESCALE_W   = 6;
    localparam int FIFO_DEPTH   = 4;
    localparam int CNT_W        = 8;

    typedef struct packed {
        logic              stp;
        logic              par;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic                   CLK;
    logic                   RST;
    logic                   rx_in;
    logic [PRESCALE_W-1:0]  cfg_prescale;
    logic                   cfg_par_en;
    logic                   cfg_par_typ;
    logic                   cfg_wr;
    logic                   cfg_pending;
    logic [PRESCALE_W-1:0]  rx_prescale;
    logic                   rx_par_en;
    logic                   rx_par_typ;
    logic                   rx_data_valid;
    logic                   rx_par_err;
    logic                   rx_stp_err;
    logic [DATA_W-1:0]      rx_p_data;
    logic                   frame_active;
    logic                   m_valid;
    logic                   m_ready;
    logic [DATA_W-1:0]      m_data;
    logic                   m_par_err;
    logic                   m_stp_err;
    logic [2:0]             fifo_count;
    logic                   overflow;
    logic                   ovf_clr;
    logic [CNT_W-1:0]       err_cnt;
    logic [CNT_W-1:0]       to_cnt;
    logic                   cnt_clr;

    int   checks;
    int   errors;
    ent_t exp_q[$];
    bit   rand_ready;
    bit   ready_force;

    int   exp_prescale;
    bit   exp_par_en;
    bit   exp_par_typ;
    int   shd_prescale;
    bit   shd_par_en;
    bit   shd_par_typ;
    bit   exp_pending;
    int   exp_err;
    int   exp_to;
    bit   exp_ovf;

    uart_rx_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .rx_in         (rx_in),
        .cfg_prescale  (cfg_prescale),
        .cfg_par_en    (cfg_par_en),
        .cfg_par_typ   (cfg_par_typ),
        .cfg_wr        (cfg_wr),
        .cfg_pending   (cfg_pending),
        .rx_prescale   (rx_prescale),
        .rx_par_en     (rx_par_en),
        .rx_par_typ    (rx_par_typ),
        .rx_data_valid (rx_data_valid),
        .rx_par_err    (rx_par_err),
        .rx_stp_err    (rx_stp_err),
        .rx_p_data     (rx_p_data),
        .frame_active  (frame_active),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_par_err     (m_par_err),
        .m_stp_err     (m_stp_err),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr),
        .err_cnt       (err_cnt),
        .to_cnt        (to_cnt),
        .cnt_clr       (cnt_clr)
    );

    // 10 ns clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Runaway guard
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Consumer ready: random or forced, updated just after each edge
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Scoreboard monitor: every accepted head entry must match the oldest expected one
    initial begin
        ent_t e;
        forever begin
            @(negedge CLK);
            if (RST && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_entry: got data 0x%0h, expected no entry", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check_output("head_data", 32'(m_data), 32'(e.data));
                    check_output("head_par_err", 32'(m_par_err), 32'(e.par));
                    check_output("head_stp_err", 32'(m_stp_err), 32'(e.stp));
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check_output({tag, "_m_valid"}, 32'(m_valid), 0);
        check_output({tag, "_m_data"}, 32'(m_data), 0);
        check_output({tag, "_m_flags"}, 32'({m_stp_err, m_par_err}), 0);
        check_output({tag, "_fifo_count"}, 32'(fifo_count), 0);
        check_output({tag, "_rx_prescale"}, 32'(rx_prescale), 8);
        check_output({tag, "_rx_parity"}, 32'({rx_par_typ, rx_par_en}), 0);
        check_output({tag, "_cfg_pending"}, 32'(cfg_pending), 0);
        check_output({tag, "_frame_active"}, 32'(frame_active), 0);
        check_output({tag, "_overflow"}, 32'(overflow), 0);
        check_output({tag, "_err_cnt"}, 32'(err_cnt), 0);
        check_output({tag, "_to_cnt"}, 32'(to_cnt), 0);
    endtask

    // End-of-frame strobe while ACTIVE; predicts whether the entry lands in the FIFO
    task automatic strobe_frame(input logic [7:0] data, input int kind, input bit ready_at_strobe);
        ent_t e;
        rx_p_data     = data;
        rx_data_valid = (kind == 0);
        rx_par_err    = (kind == 1) || (kind == 3);
        rx_stp_err    = (kind == 2) || (kind == 3);
        e.data = data;
        e.par  = rx_par_err;
        e.stp  = rx_stp_err;
        if (ready_at_strobe) begin
            ready_force = 1'b1;
        end
        if ((exp_q.size() < FIFO_DEPTH) || ready_at_strobe) begin
            exp_q.push_back(e);
        end else begin
            exp_ovf = 1'b1;
        end
        if ((kind != 0) && (exp_err < 255)) begin
            exp_err++;
        end
        tick();
        rx_data_valid = 1'b0;
        rx_par_err    = 1'b0;
        rx_stp_err    = 1'b0;
        ready_force   = 1'b0;
    endtask

    // Full frame: idle line, start edge, some bit time, end strobe, line back high
    task automatic apply_stimulus(input logic [7:0] data, input int kind, input int delay, input bit ready_at_strobe);
        int w;
        if (rand_ready) begin
            w = 0;
            while ((exp_q.size() >= FIFO_DEPTH) && (w < 200)) begin
                tick();
                w++;
            end
            if (w >= 200) begin
                check_output("drain_before_frame", 32'(exp_q.size()), FIFO_DEPTH - 1);
            end
        end
        rx_in = 1'b1;
        tick();
        rx_in = 1'b0;
        tick();
        repeat (delay) tick();
        strobe_frame(data, kind, ready_at_strobe);
        rx_in = 1'b1;
    endtask

    task automatic cfg_write(input int ps, input bit pe, input bit pt);
        cfg_prescale = PRESCALE_W'(ps);
        cfg_par_en   = pe;
        cfg_par_typ  = pt;
        cfg_wr       = 1'b1;
        if (ps != 0) begin
            shd_prescale = ps;
            shd_par_en   = pe;
            shd_par_typ  = pt;
            exp_pending  = 1'b1;
        end
        tick();
        cfg_wr = 1'b0;
    endtask

    // Line held low with no end strobe: frame must abort after one frame time
    task automatic run_timeout();
        int n;
        int iter;
        int expect_len;
        expect_len = exp_prescale * (11 + int'(exp_par_en));
        rx_in = 1'b1;
        tick();
        rx_in = 1'b0;
        n = 0;
        iter = 0;
        while (iter < 2000) begin
            @(negedge CLK);
            iter++;
            if (frame_active) begin
                n++;
            end else if (n > 0) begin
                break;
            end
        end
        if (exp_to < 255) begin
            exp_to++;
        end
        check_output("timeout_len", 32'(n), 32'(expect_len));
        check_output("timeout_to_cnt", 32'(to_cnt), 32'(exp_to));
        repeat (3) @(negedge CLK);
        check_output("no_retrigger", 32'(frame_active), 0);
        tick();
        rx_in = 1'b1;
        tick();
    endtask

    task automatic drain(input string tag);
        int w;
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        w = 0;
        while ((exp_q.size() != 0) && (w < 500)) begin
            tick();
            w++;
        end
        tick();
        tick();
        ready_force = 1'b0;
        tick();
        check_output({tag, "_queue_left"}, 32'(exp_q.size()), 0);
        check_output({tag, "_fifo_count"}, 32'(fifo_count), 0);
        exp_q.delete();
    endtask

    initial begin
        int op;
        checks        = 0;
        errors        = 0;
        rand_ready    = 1'b0;
        ready_force   = 1'b0;
        RST           = 1'b0;
        rx_in         = 1'b1;
        cfg_prescale  = '0;
        cfg_par_en    = 1'b0;
        cfg_par_typ   = 1'b0;
        cfg_wr        = 1'b0;
        rx_data_valid = 1'b0;
        rx_par_err    = 1'b0;
        rx_stp_err    = 1'b0;
        rx_p_data     = '0;
        ovf_clr       = 1'b0;
        cnt_clr       = 1'b0;
        exp_prescale  = 8;
        exp_par_en    = 1'b0;
        exp_par_typ   = 1'b0;
        exp_pending   = 1'b0;
        exp_err       = 0;
        exp_to        = 0;
        exp_ovf       = 1'b0;

        repeat (3) @(posedge CLK);
        #2;
        check_reset_state("por");
        #1;
        RST = 1'b1;
        tick();

        // Good frame 0xA5, head appears one cycle after the push
        apply_stimulus(8'hA5, 0, 3, 1'b0);
        @(negedge CLK);
        check_output("a5_m_valid", 32'(m_valid), 1);
        check_output("a5_m_data", 32'(m_data), 32'hA5);
        check_output("a5_flags", 32'({m_stp_err, m_par_err}), 0);
        check_output("a5_fifo_count", 32'(fifo_count), 1);
        drain("a5");

        // Abort by timeout at prescale 8, no parity
        run_timeout();
        check_output("timeout_no_push", 32'(fifo_count), 0);

        // Config write during a frame waits for the line to go idle
        rx_in = 1'b0;
        tick();
        cfg_write(16, 1'b0, 1'b0);
        @(negedge CLK);
        check_output("cfg_mid_pending", 32'(cfg_pending), 1);
        check_output("cfg_mid_prescale", 32'(rx_prescale), 8);
        tick();
        strobe_frame(8'h5A, 0, 1'b0);
        tick();
        check_output("cfg_done_pending", 32'(cfg_pending), 1);
        check_output("cfg_done_prescale", 32'(rx_prescale), 8);
        rx_in = 1'b1;
        tick();
        tick();
        exp_prescale = shd_prescale;
        exp_par_en   = shd_par_en;
        exp_par_typ  = shd_par_typ;
        exp_pending  = 1'b0;
        check_output("cfg_applied_prescale", 32'(rx_prescale), 16);
        check_output("cfg_applied_pending", 32'(cfg_pending), 0);
        drain("cfg");

        // Zero prescale write is ignored
        cfg_write(0, 1'b1, 1'b1);
        tick();
        check_output("cfg_zero_pending", 32'(cfg_pending), 0);
        check_output("cfg_zero_prescale", 32'(rx_prescale), 16);
        check_output("cfg_zero_par_en", 32'(rx_par_en), 0);

        // Parity error frame
        apply_stimulus(8'h3C, 1, 2, 1'b0);
        @(negedge CLK);
        check_output("par_m_data", 32'(m_data), 32'h3C);
        check_output("par_m_par_err", 32'(m_par_err), 1);
        check_output("par_m_stp_err", 32'(m_stp_err), 0);
        check_output("par_err_cnt", 32'(err_cnt), 1);
        drain("par");

        // Error counter saturation
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(8'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1'b0);
        end
        tick();
        check_output("err_saturated", 32'(err_cnt), 32'(exp_err));
        check_output("err_sat_value", 32'(exp_err), 255);
        drain("sat");

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        exp_err = 0;
        exp_to  = 0;
        check_output("clr_err_cnt", 32'(err_cnt), 0);
        check_output("clr_to_cnt", 32'(to_cnt), 0);

        // Overflow: consumer stalled, fifth frame lost, then full+pop accepted
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(8'(8'h10 + i), 0, 1, 1'b0);
        end
        @(negedge CLK);
        check_output("ovf_fifo_count", 32'(fifo_count), 4);
        check_output("ovf_overflow", 32'(overflow), 32'(exp_ovf));
        rx_in = 1'b1;
        tick();
        rx_in = 1'b0;
        tick();
        strobe_frame(8'h77, 0, 1'b1);
        rx_in = 1'b1;
        @(negedge CLK);
        check_output("ovf_full_pop_count", 32'(fifo_count), 4);
        check_output("ovf_still_set", 32'(overflow), 1);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        check_output("ovf_cleared", 32'(overflow), 0);
        drain("ovf");

        // Randomized mix of frames, config changes and timeouts
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 7));
            if (op <= 5) begin
                apply_stimulus(8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 8)), 1'b0);
            end else if (op == 6) begin
                cfg_write(int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                tick();
                if (exp_pending) begin
                    exp_prescale = shd_prescale;
                    exp_par_en   = shd_par_en;
                    exp_par_typ  = shd_par_typ;
                    exp_pending  = 1'b0;
                end
                check_output("rand_cfg_prescale", 32'(rx_prescale), 32'(exp_prescale));
                check_output("rand_cfg_parity", 32'({rx_par_typ, rx_par_en}), 32'({exp_par_typ, exp_par_en}));
                check_output("rand_cfg_pending", 32'(cfg_pending), 0);
            end else begin
                run_timeout();
            end
        end
        tick();
        check_output("rand_err_cnt", 32'(err_cnt), 32'(exp_err));
        check_output("rand_to_cnt", 32'(to_cnt), 32'(exp_to));
        drain("rand");

        // Asynchronous reset in the middle of a frame with entries buffered
        apply_stimulus(8'hC1, 0, 1, 1'b0);
        apply_stimulus(8'hC2, 2, 1, 1'b0);
        rx_in = 1'b1;
        tick();
        rx_in = 1'b0;
        tick();
        tick();
        @(negedge CLK);
        check_output("prereset_count", 32'(fifo_count), 2);
        check_output("prereset_active", 32'(frame_active), 1);
        #2;
        RST = 1'b0;
        #1;
        exp_q.delete();
        check_reset_state("midrst");
        rx_in = 1'b1;
        tick();
        #3;
        RST = 1'b1;
        tick();
        check_output("postrst_m_valid", 32'(m_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Sequencing and buffering controller for the UART receive datapath. It owns the receiver configuration (prescale, parity enable/type) and applies new settings only between frames. It tracks frame activity on the line and recovers from aborted frames by timeout. Received bytes and their error status go into a small result FIFO drained by a valid/ready consumer, with saturating error and timeout statistics.

Parameters:
DATA_W, 8, received data width (matches receiver output)
PRESCALE_W, 6, prescale field width
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)
TO_W, 10, frame timeout counter width
RST_PRESCALE, 8, prescale value after reset
CNT_W, 8, width of statistics counters

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
rx_in  in  1  serial line (same net the receiver samples)
cfg_prescale  in  PRESCALE_W  requested prescale
cfg_par_en  in  1  requested parity enable
cfg_par_typ  in  1  requested parity type (0 even, 1 odd)
cfg_wr  in  1  one-cycle strobe: capture cfg_* into pending shadow
cfg_pending  out  1  shadow captured but not yet applied
rx_prescale  out  PRESCALE_W  active prescale to receiver
rx_par_en  out  1  active parity enable to receiver
rx_par_typ  out  1  active parity type to receiver
rx_data_valid  in  1  receiver good-frame strobe
rx_par_err  in  1  receiver parity-error strobe
rx_stp_err  in  1  receiver stop-error strobe
rx_p_data  in  DATA_W  receiver parallel data
frame_active  out  1  frame in progress
m_valid  out  1  FIFO head valid
m_ready  in  1  consumer accepts head
m_data  out  DATA_W  head data
m_par_err  out  1  head parity-error flag
m_stp_err  out  1  head stop-error flag
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
overflow  out  1  sticky: frame dropped on full FIFO
ovf_clr  in  1  clear overflow
err_cnt  out  CNT_W  saturating count of frames with parity or stop error
to_cnt  out  CNT_W  saturating count of timeouts
cnt_clr  in  1  clear err_cnt and to_cnt

Behaviour:
- Reset: active config = {RST_PRESCALE,0,0}; cfg_pending 0; FSM IDLE; FIFO empty; m_valid 0; m_data/flags 0; fifo_count 0; overflow 0; counters 0.
- rx_data_valid, rx_par_err and rx_stp_err are single-cycle end-of-frame strobes. "End strobe" = OR of the three. rx_p_data is valid on that cycle.
- cfg_wr: captures cfg_* into the shadow and sets cfg_pending next cycle. A write with cfg_prescale==0 is ignored. A later write overwrites the shadow.
- FSM IDLE: rx_in low (start edge) -> ACTIVE, clear timer. Otherwise, if cfg_pending, copy shadow to active outputs and clear cfg_pending in the same edge. If a start edge and a pending apply coincide, start wins and the apply waits for the next IDLE cycle. cfg_wr and an apply in the same cycle: the new value is captured and stays pending.
- FSM ACTIVE: frame_active=1. Timer increments each cycle.
  - End strobe -> push, then DONE.
  - Timer reaches limit with no strobe -> to_cnt++ (saturating), no push, then DONE.
  - Limit = rx_prescale*(11+rx_par_en) - 1, computed at TO_W width.
- FSM DONE: wait for rx_in high (line idle), then IDLE. This prevents a held-low line from retriggering.
- Push: entry {rx_stp_err, rx_par_err, rx_p_data}.
  - If rx_par_err or rx_stp_err is set, err_cnt++ (saturating).
  - Full and no pop in the same cycle: entry dropped, overflow set.
  - Full with simultaneous pop: push accepted.
  - Overflow set has priority over ovf_clr in the same cycle. cnt_clr has priority over increment.
- FIFO: first-word-fall-through. m_valid = !empty. Pop when m_valid & m_ready. Pointers wrap modulo FIFO_DEPTH. Push-to-m_valid latency is 1 cycle.
- Mid-operation reset returns everything to reset values immediately (asynchronous).

Decomposition:
- Shared uart_rx_pkg holds FSM state encoding (IDLE/ACTIVE/DONE), the frame-bit constants (10 base, +1 parity) and the FIFO entry field offsets.
- One sub-module is natural: uart_rx_res_fifo (synchronous FWFT FIFO, parameterised width/depth, full/empty/count).

Test Plan:
- After reset, drive frame 0xA5 (no parity, prescale 8); strobe rx_data_valid with rx_p_data=0xA5 -> m_valid high next cycle, m_data=0xA5, flags 0, fifo_count=1.
- cfg_wr prescale=16 while ACTIVE -> rx_prescale stays 8, cfg_pending=1 until the frame ends and rx_in is high; then rx_prescale=16 and cfg_pending=0.
- rx_in low with no end strobe, prescale 8, no parity -> timeout after 88 cycles; to_cnt=1, no push, returns to IDLE once rx_in goes high.
- Strobe rx_par_err with data 0x3C -> entry data 0x3C, m_par_err=1, err_cnt=1; repeat 300 times -> err_cnt saturates at 255.
- m_ready=0, push 5 frames with depth 4 -> fifo_count=4, overflow=1, 5th frame lost; on the next push with full and m_ready=1 the push is accepted and count stays 4.
- Assert RST low mid-frame with FIFO at 2 entries -> all outputs return to reset values; rx_prescale=8.
